// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption core. ARK and SubBytes work on one state word per cycle.
// ShiftRows+MixColumns produce one column per cycle. Round keys come from an external expander.

module aes_sbox (
  input  logic [7:0] value,
  output logic [7:0] image
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // x^254 is the GF(2^8) multiplicative inverse. It also maps 0 to 0, as the S-box requires.
  always_comb begin
    sq  = value;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    image = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
            {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_round_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data_in,
  input  logic        key_done,
  input  logic [31:0] key_word,
  output logic [3:0]  key_round,
  output logic [1:0]  key_index,
  output logic [31:0] data_out,
  output logic        out_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, LOAD, WAITKEY, ARK, SUB, MIX, OUT} fsm_t;

  fsm_t                 fsm_state;
  fsm_t                 fsm_next;
  logic [0:3][0:3][7:0] aes_state;
  logic [0:3][0:3][7:0] shadow;
  logic [1:0]           cnt;
  logic [1:0]           cnt_next;
  logic [3:0]           round;
  logic [3:0]           round_next;
  logic [31:0]          data_q;
  logic [0:3][7:0]      cur_word;
  logic [0:3][7:0]      sub_word;
  logic [0:3][7:0]      sr_col;
  logic [0:3][7:0]      mix_word;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [0:3][7:0] mix_column(input logic [0:3][7:0] a);
    logic [0:3][7:0] m;
    m[0] = xtime(a[0] ^ a[1]) ^ a[1] ^ a[2] ^ a[3];
    m[1] = xtime(a[1] ^ a[2]) ^ a[2] ^ a[3] ^ a[0];
    m[2] = xtime(a[2] ^ a[3]) ^ a[3] ^ a[0] ^ a[1];
    m[3] = xtime(a[3] ^ a[0]) ^ a[0] ^ a[1] ^ a[2];
    return m;
  endfunction

  assign cur_word = aes_state[cnt];

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .value(cur_word[b]),
      .image(sub_word[b])
    );
  end

  // ShiftRows folded into the column read: row r comes from the column r places to the right.
  assign sr_col[0] = aes_state[cnt][0];
  assign sr_col[1] = aes_state[cnt + 2'd1][1];
  assign sr_col[2] = aes_state[cnt + 2'd2][2];
  assign sr_col[3] = aes_state[cnt + 2'd3][3];
  assign mix_word  = ((round == 4'd10) ? sr_col : mix_column(sr_col)) ^ key_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm_state <= IDLE;
    else       fsm_state <= fsm_next;
  end

  always_comb begin
    fsm_next   = fsm_state;
    cnt_next   = 2'd0;
    round_next = round;
    case (fsm_state)
      IDLE: begin
        round_next = 4'd0;
        if (start) fsm_next = LOAD;
      end
      LOAD: begin
        cnt_next = cnt + 2'd1;
        if (cnt == 2'd3) fsm_next = WAITKEY;
      end
      WAITKEY: begin
        if (key_done) fsm_next = ARK;
      end
      ARK: begin
        cnt_next = cnt + 2'd1;
        if (cnt == 2'd3) begin
          fsm_next   = SUB;
          round_next = 4'd1;
        end
      end
      SUB: begin
        cnt_next = cnt + 2'd1;
        if (cnt == 2'd3) fsm_next = MIX;
      end
      MIX: begin
        cnt_next = cnt + 2'd1;
        if (cnt == 2'd3) begin
          if (round == 4'd10) begin
            fsm_next = OUT;
          end else begin
            fsm_next   = SUB;
            round_next = round + 4'd1;
          end
        end
      end
      OUT: begin
        cnt_next = cnt + 2'd1;
        if (cnt == 2'd3) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (fsm_state != IDLE);
    out_valid = (fsm_state == OUT);
    done      = out_valid && (cnt == 2'd3);
    data_out  = out_valid ? aes_state[cnt] : data_q;
  end

  // Key address is computed from next-cycle FSM values, so key_word is settled when consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aes_state <= '0;
      shadow    <= '0;
      cnt       <= 2'd0;
      round     <= 4'd0;
      key_round <= 4'd0;
      key_index <= 2'd0;
      data_q    <= 32'h0;
    end else begin
      cnt       <= cnt_next;
      round     <= round_next;
      data_q    <= data_out;
      key_round <= (fsm_next == SUB || fsm_next == MIX) ? round_next : 4'd0;
      key_index <= (fsm_next == ARK || fsm_next == SUB || fsm_next == MIX) ? cnt_next : 2'd0;
      case (fsm_state)
        LOAD: aes_state[cnt] <= data_in;
        ARK:  aes_state[cnt] <= cur_word ^ key_word;
        SUB:  aes_state[cnt] <= sub_word;
        MIX: begin
          shadow[cnt] <= mix_word;
          if (cnt == 2'd3) aes_state <= {shadow[0], shadow[1], shadow[2], mix_word};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine using the FIPS-197 vectors and a behavioural key expander.

module tb_aes_round_engine;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic        key_done;
  logic [31:0] key_word;
  logic [3:0]  key_round;
  logic [1:0]  key_index;
  logic [31:0] data_out;
  logic        out_valid;
  logic        busy;
  logic        done;

  logic [31:0] rk [0:43];
  logic [31:0] last_out;
  int          checks;
  int          errors;

  aes_round_engine dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .key_done (key_done),
    .key_word (key_word),
    .key_round(key_round),
    .key_index(key_index),
    .data_out (data_out),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behaves like the key expander: the selected round-key word is valid combinationally.
  always_comb begin
    key_word = 32'h0;
    if (key_round <= 4'd10) key_word = rk[{key_round, key_index}];
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    for (int x = 1; x < 256; x++)
      if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) rk[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = rk[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);
      end
      rk[i] = rk[i-4] ^ t;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Cycle k = 0 is the start cycle. Outputs are checked and inputs driven at each falling edge.
  task automatic run_op(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct,
                        input int delay, input int extra_start, input int reset_at, input bit late_start);
    int last_k;
    int ov_first;
    int rel;
    bit aborted;
    bit ov_exp;
    expand_key(key);
    last_k   = (reset_at >= 0) ? 100 : 96 + delay;
    ov_first = 90 + delay;
    aborted  = 1'b0;
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      if (reset_at >= 0 && k > reset_at) aborted = 1'b1;
      if (aborted) begin
        last_out = 32'h0;
        check_output($sformatf("abort_busy@%0d", k), 32'(busy), 32'd0);
        check_output($sformatf("abort_out_valid@%0d", k), 32'(out_valid), 32'd0);
        check_output($sformatf("abort_done@%0d", k), 32'(done), 32'd0);
        check_output($sformatf("abort_data_out@%0d", k), data_out, last_out);
        check_output($sformatf("abort_key_round@%0d", k), 32'(key_round), 32'd0);
        check_output($sformatf("abort_key_index@%0d", k), 32'(key_index), 32'd0);
      end else begin
        ov_exp = (k >= ov_first) && (k <= ov_first + 3);
        if (ov_exp) last_out = ct[127 - 32*(k - ov_first) -: 32];
        check_output($sformatf("busy@%0d", k), 32'(busy), 32'((k >= 1) && (k <= 93 + delay)));
        check_output($sformatf("out_valid@%0d", k), 32'(out_valid), 32'(ov_exp));
        check_output($sformatf("done@%0d", k), 32'(done), 32'(k == ov_first + 3));
        check_output($sformatf("data_out@%0d", k), data_out, last_out);
        if (k >= 5 && k <= 5 + delay)
          check_output($sformatf("wait_key_round@%0d", k), 32'(key_round), 32'd0);
        if (k >= 6 + delay && k <= 9 + delay) begin
          check_output($sformatf("ark_key_round@%0d", k), 32'(key_round), 32'd0);
          check_output($sformatf("ark_key_index@%0d", k), 32'(key_index), 32'(k - 6 - delay));
        end
        rel = k - 10 - delay;
        if (rel >= 0 && rel < 80 && (rel % 8) >= 4) begin
          check_output($sformatf("mix_key_round@%0d", k), 32'(key_round), 32'(rel / 8 + 1));
          check_output($sformatf("mix_key_index@%0d", k), 32'(key_index), 32'(rel % 8 - 4));
        end
      end
      start    = (k == 0) || (k == extra_start) || (late_start && (k == 93 + delay));
      data_in  = 32'h0;
      if (k >= 1 && k <= 4) data_in = pt[127 - 32*(k-1) -: 32];
      key_done = ((delay == 0) || (k >= 5 + delay)) && !((k >= 30 + delay) && (k < 40 + delay));
      if (reset_at >= 0 && k == reset_at)     reset = 1'b1;
      if (reset_at >= 0 && k == reset_at + 2) reset = 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    data_in  = 32'h0;
    key_done = 1'b0;
    last_out = 32'h0;
    expand_key(128'h0);
    repeat (2) @(negedge clk);
    check_output("reset_key_round", 32'(key_round), 32'd0);
    check_output("reset_key_index", 32'(key_index), 32'd0);
    check_output("reset_data_out", data_out, 32'h0);
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_output("idle_busy", 32'(busy), 32'd0);

    $display("[TB] FIPS-197 App. B");
    run_op(KEY_B, PT_B, CT_B, 0, -1, -1, 1'b0);
    $display("[TB] App. B with a second start at T+40");
    run_op(KEY_B, PT_B, CT_B, 0, 40, -1, 1'b0);
    $display("[TB] App. B with key_done low for 20 cycles");
    run_op(KEY_B, PT_B, CT_B, 20, -1, -1, 1'b0);
    $display("[TB] App. C.1 aborted by reset at T+50");
    run_op(KEY_C, PT_C, CT_C, 0, -1, 50, 1'b0);
    $display("[TB] App. C.1 with start on the final output cycle");
    run_op(KEY_C, PT_C, CT_C, 0, -1, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_engine.md
AES_ROUND_ENGINE -- requirements
Module: aes_round_engine

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: clock; all state updates on the rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port `start`, input, 1 bit: one-cycle pulse that begins one AES-128 encryption.
REQ-004 SHALL have port `data_in`, input, 32 bits: plaintext word, most-significant word first, over the 4 cycles after `start`.
REQ-005 SHALL have port `key_done`, input, 1 bit: high when the key expander's round keys are valid.
REQ-006 SHALL have port `key_word`, input, 32 bits: round-key word selected by `key_round`/`key_index`, combinationally valid in the same cycle.
REQ-007 SHALL have port `key_round`, output, 4 bits: round-key number requested (0..10).
REQ-008 SHALL have port `key_index`, output, 2 bits: word of that round key requested (0 = bits 127:96).
REQ-009 SHALL have port `data_out`, output, 32 bits: ciphertext word, most-significant word first.
REQ-010 SHALL have port `out_valid`, output, 1 bit: `data_out` is valid this cycle.
REQ-011 SHALL have port `busy`, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port `done`, output, 1 bit: one-cycle pulse, coincident with the last ciphertext word.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, WAITKEY, ARK, SUB, MIX, OUT.
REQ-014 SHALL hold a 128-bit state register, word 0 = bits 127:96, column-major per FIPS-197.
- In IDLE, `start`=1 SHALL move to LOAD.
- In LOAD, SHALL capture `data_in` into words 0,1,2,3 on 4 consecutive edges (counter 0..3), then go to WAITKEY.
REQ-015 In WAITKEY, SHALL remain while `key_done`=0; with `key_done`=1, SHALL go to ARK on the next edge.
REQ-016 In ARK, SHALL XOR word c (c = 0..3, one per cycle) with `key_word` while `key_round`=0 and `key_index`=c, then set round=1 and go to SUB.
REQ-017 In SUB, SHALL replace the 4 bytes of word c (one word per cycle, 4 cycles) with their S-box images.
- S-box substitution SHALL use 4 instances of the team byte S-box module `aes_sbox` (8-bit in, 8-bit out, combinational).
REQ-018 In MIX (4 cycles, c = 0..3), SHALL compute column c of ShiftRows(state).
- For round < 10, SHALL apply MixColumns to that column.
- SHALL XOR the result with `key_word`, where `key_round`=round and `key_index`=c.
- SHALL write the result to a 128-bit shadow register.
- On c=3, SHALL copy the shadow register into the state register.
REQ-019 MixColumns SHALL use xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
- All arithmetic SHALL be 8-bit GF(2^8); no carries.
REQ-020 After MIX c=3, SHALL go to SUB with round+1 if round < 10; if round = 10, SHALL go to OUT.
REQ-021 In OUT, SHALL drive words 0..3 on `data_out` with `out_valid`=1 for 4 consecutive cycles.
- `done`=1 SHALL coincide with word 3.
- SHALL then return to IDLE.
REQ-022 Latency with `key_done` already high:
- `start` in cycle T; LOAD T+1..T+4; WAITKEY T+5; ARK T+6..T+9.
- Rounds occupy T+10..T+89 (8 cycles per round).
- `out_valid` SHALL be high T+90..T+93, with `done` at T+93.
REQ-023 `start` SHALL be ignored while `busy`=1.
REQ-024 A `start` in the same cycle as the OUT-to-IDLE return SHALL be ignored; `start` is accepted only in IDLE.
REQ-025 `key_done` SHALL be sampled only in WAITKEY; a later deassertion SHALL NOT stall or abort the operation.
REQ-026 `key_round`/`key_index` SHALL be registered outputs, updated one cycle ahead of use, so `key_word` is stable during ARK/MIX cycles.
REQ-027 `data_out` SHALL hold its last value when `out_valid`=0.

Reset
REQ-028 `reset` SHALL force IDLE and clear the state, shadow, counters and round register to 0.
- Reset values: `key_round`=0, `key_index`=0, `data_out`=0, `out_valid`=0, `busy`=0, `done`=0.
REQ-029 `reset` asserted mid-operation SHALL abort immediately with no further `out_valid`/`done`.
- After release, SHALL wait in IDLE for a new `start`.

Verification
REQ-030 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> `data_out` 3925841d, 02dc09fb, dc118597, 196a0b32 at T+90..T+93, with `done` at T+93.
REQ-031 FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
REQ-032 `key_done` held low 20 cycles after LOAD -> FSM stays in WAITKEY with `busy`=1 and `key_round`=0, then output is correct and shifted +20 cycles.
REQ-033 Second `start` at T+40 -> ignored; result and timing identical to REQ-030.
REQ-034 `reset` at T+50 -> all outputs 0 next cycle and no `out_valid` afterwards; a subsequent App. C.1 run passes.
REQ-035 A bench key model SHALL assert that `key_round` sequences 0,1..10 and `key_index` sequences 0..3 in each ARK/MIX phase.
